// File: rtl/d5m_frame_gen_pkg.sv
// Shared types and constants for the synthetic D5M frame generator.
// Contents:
//   COORD_W    - width of the x/y coordinate outputs
//   state_e    - frame-timing FSM states
//   pattern_e  - test pattern selector encoding
package d5m_frame_gen_pkg;

    localparam int COORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRONT,
        ST_LINE,
        ST_HBLANK,
        ST_VBLANK
    } state_e;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'b00,
        PAT_DRAMP = 2'b01,
        PAT_CHECK = 2'b10,
        PAT_CONST = 2'b11
    } pattern_e;

endpackage

// File: rtl/d5m_frame_gen_if.sv
// Control and video bus of the synthetic D5M source.
// Control (into the generator): start, stop, frames[15:0], pattern[1:0], const_val.
// Video/status (out of the generator): fvalid, lvalid, data, x, y, eof,
//   frame_cnt[15:0], busy.
// Modports: master = the generator, slave = the consumer / bench side.
interface d5m_frame_gen_if #(
    parameter int DATA_WIDTH = 12
) ();
    import d5m_frame_gen_pkg::*;

    logic                  start;
    logic                  stop;
    logic [15:0]           frames;
    logic [1:0]            pattern;
    logic [DATA_WIDTH-1:0] const_val;

    logic                  fvalid;
    logic                  lvalid;
    logic [DATA_WIDTH-1:0] data;
    logic [COORD_W-1:0]    x;
    logic [COORD_W-1:0]    y;
    logic                  eof;
    logic [15:0]           frame_cnt;
    logic                  busy;

    modport master (
        input  start, stop, frames, pattern, const_val,
        output fvalid, lvalid, data, x, y, eof, frame_cnt, busy
    );

    modport slave (
        output start, stop, frames, pattern, const_val,
        input  fvalid, lvalid, data, x, y, eof, frame_cnt, busy
    );

endinterface

// File: rtl/d5m_pattern_gen.sv
// Registered test-pattern pixel generator.
// Ports:
//   pixclk, reset   - clock, synchronous active-high reset
//   lvalid_i        - next-cycle line valid; data is forced to 0 when low
//   x_i, y_i        - next-cycle pixel coordinates
//   pattern_i       - pattern latched for the current frame
//   const_val_i     - constant value for PAT_CONST
//   data_o          - registered pixel, aligned with the registered lvalid/x/y
module d5m_pattern_gen
    import d5m_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  pixclk,
    input  logic                  reset,
    input  logic                  lvalid_i,
    input  logic [COORD_W-1:0]    x_i,
    input  logic [COORD_W-1:0]    y_i,
    input  pattern_e              pattern_i,
    input  logic [DATA_WIDTH-1:0] const_val_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    function automatic logic [DATA_WIDTH-1:0] pixel(
        input pattern_e              pat,
        input logic [COORD_W-1:0]    px,
        input logic [COORD_W-1:0]    py,
        input logic [DATA_WIDTH-1:0] cval
    );
        logic [COORD_W:0]      sum;
        logic [DATA_WIDTH-1:0] res;
        sum = {1'b0, px} + {1'b0, py};
        case (pat)
            PAT_HRAMP: res = DATA_WIDTH'(px);
            PAT_DRAMP: res = DATA_WIDTH'(sum);
            PAT_CHECK: res = (px[3] ^ py[3]) ? '1 : '0;
            PAT_CONST: res = cval;
            default:   res = '0;
        endcase
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge pixclk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= lvalid_i ? pixel(pattern_i, x_i, y_i, const_val_i) : '0;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/d5m_frame_gen.sv
// Synthetic D5M camera source: fvalid/lvalid/raw-pixel timing with
// programmable geometry, blanking and test patterns.
// Ports:
//   pixclk  - single clock, all logic on its rising edge
//   reset   - synchronous, active-high
//   vid     - d5m_frame_gen_if.master: start/stop/frames/pattern/const_val in,
//             fvalid/lvalid/data/x/y/eof/frame_cnt/busy out (all registered)
module d5m_frame_gen
    import d5m_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int H_BLANK    = 16,
    parameter int V_BLANK    = 8
) (
    input  logic              pixclk,
    input  logic              reset,
    d5m_frame_gen_if.master   vid
);

    localparam logic [15:0]        HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0]        VB_LAST = 16'(V_BLANK - 1);
    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(IMG_HEIGHT - 1);

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [COORD_W-1:0]    x_q, x_d;
    logic [COORD_W-1:0]    y_q, y_d;
    logic [15:0]           frames_q, frames_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  stop_pend_q, stop_pend_d;
    pattern_e              pat_q, pat_d;
    logic [DATA_WIDTH-1:0] cval_q, cval_d;
    logic                  fvalid_q, fvalid_d;
    logic                  lvalid_q, lvalid_d;
    logic                  eof_q, eof_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] data_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = '0;
        y_d         = y_q;
        frames_d    = frames_q;
        frame_cnt_d = frame_cnt_q;
        stop_pend_d = stop_pend_q;
        pat_d       = pat_q;
        cval_d      = cval_q;

        // eof_q is the last pixel, so the count steps on the following cycle.
        if (eof_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (state_q != ST_IDLE && vid.stop) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                y_d = '0;
                if (vid.start) begin
                    state_d     = ST_FRONT;
                    cnt_d       = '0;
                    frames_d    = vid.frames;
                    frame_cnt_d = '0;
                    stop_pend_d = 1'b0;
                end
            end
            ST_FRONT: begin
                if (cnt_q == HB_LAST) begin
                    state_d = ST_LINE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_LINE: begin
                if (x_q == X_LAST) begin
                    cnt_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = ST_VBLANK;
                        y_d     = '0;
                    end else begin
                        state_d = ST_HBLANK;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            ST_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    state_d = ST_LINE;
                    cnt_d   = '0;
                    y_d     = y_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    cnt_d = '0;
                    // frame_cnt_q already includes the frame just finished.
                    if ((frames_q == 16'd0 || frame_cnt_q < frames_q) && !stop_pend_d) begin
                        state_d = ST_FRONT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pattern settings are frozen for the whole frame from FRONT entry.
        if (state_d == ST_FRONT && state_q != ST_FRONT) begin
            pat_d  = pattern_e'(vid.pattern);
            cval_d = vid.const_val;
        end

        fvalid_d = (state_d == ST_FRONT) || (state_d == ST_LINE) || (state_d == ST_HBLANK);
        lvalid_d = (state_d == ST_LINE);
        eof_d    = lvalid_d && (x_d == X_LAST) && (y_d == Y_LAST);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            frames_q    <= '0;
            frame_cnt_q <= '0;
            stop_pend_q <= 1'b0;
            pat_q       <= PAT_HRAMP;
            cval_q      <= '0;
            fvalid_q    <= 1'b0;
            lvalid_q    <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frames_q    <= frames_d;
            frame_cnt_q <= frame_cnt_d;
            stop_pend_q <= stop_pend_d;
            pat_q       <= pat_d;
            cval_q      <= cval_d;
            fvalid_q    <= fvalid_d;
            lvalid_q    <= lvalid_d;
            eof_q       <= eof_d;
            busy_q      <= busy_d;
        end
    end

    // Fed with next-cycle coordinates so the registered pixel lines up with x_q/y_q.
    d5m_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pat (
        .pixclk      (pixclk),
        .reset       (reset),
        .lvalid_i    (lvalid_d),
        .x_i         (x_d),
        .y_i         (y_d),
        .pattern_i   (pat_q),
        .const_val_i (cval_q),
        .data_o      (data_q)
    );

    assign vid.fvalid    = fvalid_q;
    assign vid.lvalid    = lvalid_q;
    assign vid.data      = data_q;
    assign vid.x         = x_q;
    assign vid.y         = y_q;
    assign vid.eof       = eof_q;
    assign vid.frame_cnt = frame_cnt_q;
    assign vid.busy      = busy_q;

endmodule

// File: tb/tb_d5m_frame_gen.sv
module tb_d5m_frame_gen;
    import d5m_frame_gen_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;

    d5m_frame_gen_if #(.DATA_WIDTH(12)) if0 ();
    d5m_frame_gen_if #(.DATA_WIDTH(12)) if1 ();
    d5m_frame_gen_if #(.DATA_WIDTH(4))  if2 ();

    d5m_frame_gen #(.DATA_WIDTH(12), .IMG_WIDTH(4), .IMG_HEIGHT(2), .H_BLANK(2), .V_BLANK(3))
        u0 (.pixclk(clk), .reset(rst0), .vid(if0));
    d5m_frame_gen #(.DATA_WIDTH(12), .IMG_WIDTH(16), .IMG_HEIGHT(16), .H_BLANK(2), .V_BLANK(3))
        u1 (.pixclk(clk), .reset(rst1), .vid(if1));
    d5m_frame_gen #(.DATA_WIDTH(4), .IMG_WIDTH(20), .IMG_HEIGHT(2), .H_BLANK(2), .V_BLANK(2))
        u2 (.pixclk(clk), .reset(rst2), .vid(if2));

    int nvec  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    // A run is described by its position p inside the frame period; every
    // output follows from p by division/remainder on the frame geometry.
    typedef struct {
        bit active;
        int p;
        int frames;
        bit stop_pend;
        int fcnt;
        int pat;
        int cval;
    } mdl_t;

    typedef struct {
        bit fv, lv, eof, busy;
        int data, x, y, fc;
    } exp_t;

    mdl_t m0, m1, m2;

    function automatic int mpix(int pat, int x, int y, int cval, int dw);
        int mask;
        mask = (1 << dw) - 1;
        case (pat)
            0:       return x & mask;
            1:       return (x + y) & mask;
            2:       return (((x / 8) + (y / 8)) % 2 == 1) ? mask : 0;
            default: return cval & mask;
        endcase
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit rst, bit start, bit stop, int frames,
                                   int pat, int cval, int w, int h, int hb, int vb);
        mdl_t n;
        int   ph;
        n  = m;
        ph = h * (w + hb);
        if (rst) begin
            n = '{default: 0};
        end else if (!m.active) begin
            if (start) begin
                n.active = 1; n.p = 0; n.frames = frames; n.fcnt = 0;
                n.stop_pend = 0; n.pat = pat; n.cval = cval;
            end
        end else begin
            if (stop) n.stop_pend = 1;
            n.p = m.p + 1;
            if (n.p == ph) n.fcnt = (m.fcnt + 1) % 65536;
            if (n.p == ph + vb) begin
                n.p = 0;
                if ((n.frames == 0 || n.fcnt < n.frames) && !n.stop_pend) begin
                    n.pat = pat; n.cval = cval;
                end else begin
                    n.active = 0;
                end
            end
        end
        return n;
    endfunction

    function automatic exp_t mexp(mdl_t m, int w, int h, int hb, int dw);
        exp_t e;
        int   ph, line, r;
        e = '{default: 0};
        e.fc = m.fcnt;
        if (m.active) begin
            e.busy = 1;
            ph = h * (w + hb);
            if (m.p < ph) begin
                e.fv = 1;
                line = m.p / (w + hb);
                r    = m.p % (w + hb);
                if (r >= hb) begin
                    e.lv   = 1;
                    e.x    = r - hb;
                    e.y    = line;
                    e.eof  = (e.x == w - 1) && (line == h - 1);
                    e.data = mpix(m.pat, e.x, e.y, m.cval, dw);
                end else begin
                    e.y = (line == 0) ? 0 : line - 1;
                end
            end
        end
        return e;
    endfunction

    function automatic logic [67:0] pack(bit fv, bit lv, bit eof, bit busy,
                                         int data, int x, int y, int fc);
        return {fv, lv, eof, busy, 16'(data), 16'(x), 16'(y), 16'(fc)};
    endfunction

    function automatic logic [67:0] epack(exp_t e);
        return pack(e.fv, e.lv, e.eof, e.busy, e.data, e.x, e.y, e.fc);
    endfunction

    task automatic chk(string nm, logic [67:0] act, logic [67:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @%0t: got %h want %h (fv,lv,eof,busy|data|x|y|fcnt)", nm, $time, act, exp);
        end
    endtask

    task automatic chk1(string nm, int act, int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        m0 <= mstep(m0, rst0, if0.start, if0.stop, int'(if0.frames), int'(if0.pattern),
                    int'(if0.const_val), 4, 2, 2, 3);
        m1 <= mstep(m1, rst1, if1.start, if1.stop, int'(if1.frames), int'(if1.pattern),
                    int'(if1.const_val), 16, 16, 2, 3);
        m2 <= mstep(m2, rst2, if2.start, if2.stop, int'(if2.frames), int'(if2.pattern),
                    int'(if2.const_val), 20, 2, 2, 2);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("u0 outputs", pack(if0.fvalid, if0.lvalid, if0.eof, if0.busy, int'(if0.data),
                int'(if0.x), int'(if0.y), int'(if0.frame_cnt)), epack(mexp(m0, 4, 2, 2, 12)));
            chk("u1 outputs", pack(if1.fvalid, if1.lvalid, if1.eof, if1.busy, int'(if1.data),
                int'(if1.x), int'(if1.y), int'(if1.frame_cnt)), epack(mexp(m1, 16, 16, 2, 12)));
            chk("u2 outputs", pack(if2.fvalid, if2.lvalid, if2.eof, if2.busy, int'(if2.data),
                int'(if2.x), int'(if2.y), int'(if2.frame_cnt)), epack(mexp(m2, 20, 2, 2, 4)));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic go_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int eofs, late_fv;
        bit lv;
        rst0 = 1; rst1 = 1; rst2 = 1;
        if0.start = 0; if0.stop = 0; if0.frames = 0; if0.pattern = 0; if0.const_val = 0;
        if1.start = 0; if1.stop = 0; if1.frames = 0; if1.pattern = 0; if1.const_val = 0;
        if2.start = 0; if2.stop = 0; if2.frames = 0; if2.pattern = 0; if2.const_val = 0;
        go_edge();
        go_edge();
        chk_en = 1;
        chk("reset state u0", pack(if0.fvalid, if0.lvalid, if0.eof, if0.busy, int'(if0.data),
            int'(if0.x), int'(if0.y), int'(if0.frame_cnt)), '0);
        rst0 = 0; rst1 = 0; rst2 = 0;
        go_edge();

        // Basic 4x2 frame, horizontal ramp, single frame.
        if0.frames = 1; if0.pattern = 2'b00; if0.start = 1;
        go_edge();
        if0.start = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) go_edge();
            lv = (k >= 3 && k <= 6) || (k >= 9 && k <= 12);
            chk1("t1 fvalid", int'(if0.fvalid), (k <= 12) ? 1 : 0);
            chk1("t1 lvalid", int'(if0.lvalid), lv ? 1 : 0);
            chk1("t1 data", int'(if0.data), lv ? ((k <= 6) ? k - 3 : k - 9) : 0);
            chk1("t1 eof", int'(if0.eof), (k == 12) ? 1 : 0);
            chk1("t1 busy", int'(if0.busy), (k <= 15) ? 1 : 0);
            chk1("t1 frame_cnt", int'(if0.frame_cnt), (k >= 13) ? 1 : 0);
        end

        // Continuous run stopped during frame 3.
        go_edge();
        if0.frames = 0; if0.start = 1;
        go_edge();
        if0.start = 0;
        eofs = 0; late_fv = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) go_edge();
            if (k == 36) if0.stop = 1;
            if (k == 37) if0.stop = 0;
            eofs += int'(if0.eof);
            if (k >= 46 && if0.fvalid) late_fv++;
            if (k == 45) chk1("t2 busy last vblank", int'(if0.busy), 1);
            if (k == 46) begin
                chk1("t2 busy fell", int'(if0.busy), 0);
                chk1("t2 frame_cnt", int'(if0.frame_cnt), 3);
            end
        end
        chk1("t2 eof count", eofs, 3);
        chk1("t2 no 4th frame", late_fv, 0);

        // Constant pattern.
        if0.frames = 1; if0.pattern = 2'b11; if0.const_val = 12'hABC; if0.start = 1;
        go_edge();
        if0.start = 0;
        go_edge();
        go_edge();
        chk1("t2b const data", int'(if0.data), 12'hABC);
        repeat (16) go_edge();

        // 16x16 checkerboard.
        if1.frames = 1; if1.pattern = 2'b10; if1.start = 1;
        go_edge();
        if1.start = 0;
        for (int k = 1; k <= 295; k++) begin
            if (k > 1) go_edge();
            if (k == 3) begin
                chk1("t3 x(0,0)", int'(if1.x), 0);
                chk1("t3 data(0,0)", int'(if1.data), 0);
            end
            if (k == 11) begin
                chk1("t3 x(8,0)", int'(if1.x), 8);
                chk1("t3 data(8,0)", int'(if1.data), 12'hFFF);
            end
            if (k == 137) chk1("t3 data(8,7)", int'(if1.data), 12'hFFF);
            if (k == 155) begin
                chk1("t3 y(8,8)", int'(if1.y), 8);
                chk1("t3 data(8,8)", int'(if1.data), 0);
            end
            if (k == 292) chk1("t3 busy end", int'(if1.busy), 0);
        end

        // Reset mid-LINE at x=5 of frame 2.
        if1.frames = 0; if1.pattern = 2'b00; if1.start = 1;
        go_edge();
        if1.start = 0;
        repeat (298) go_edge();
        chk1("t4 x before reset", int'(if1.x), 5);
        chk1("t4 frame_cnt before reset", int'(if1.frame_cnt), 1);
        rst1 = 1;
        go_edge();
        rst1 = 0;
        chk("t4 after reset", pack(if1.fvalid, if1.lvalid, if1.eof, if1.busy, int'(if1.data),
            int'(if1.x), int'(if1.y), int'(if1.frame_cnt)), '0);
        if1.frames = 1; if1.start = 1;
        go_edge();
        if1.start = 0;
        chk1("t4 restart fvalid", int'(if1.fvalid), 1);
        chk1("t4 restart frame_cnt", int'(if1.frame_cnt), 0);
        go_edge();
        go_edge();
        chk1("t4 restart lvalid", int'(if1.lvalid), 1);
        chk1("t4 restart x", int'(if1.x), 0);
        chk1("t4 restart y", int'(if1.y), 0);
        repeat (295) go_edge();

        // Start while busy and mid-frame pattern change.
        if1.frames = 2; if1.pattern = 2'b00; if1.start = 1;
        go_edge();
        if1.start = 0;
        for (int k = 1; k <= 590; k++) begin
            if (k > 1) go_edge();
            if (k == 100) begin
                if1.pattern = 2'b01; if1.frames = 5; if1.start = 1;
            end
            if (k == 101) if1.start = 0;
            if (k == 186) begin
                chk1("t5 frame1 x", int'(if1.x), 3);
                chk1("t5 frame1 data", int'(if1.data), 3);
            end
            if (k == 333) chk1("t5 frame2 data", int'(if1.data), 5);
            if (k == 582) chk1("t5 busy last", int'(if1.busy), 1);
            if (k == 583) begin
                chk1("t5 busy fell", int'(if1.busy), 0);
                chk1("t5 frame_cnt", int'(if1.frame_cnt), 2);
            end
        end

        // 4-bit ramp wrap on a 20-wide line.
        if2.frames = 1; if2.pattern = 2'b00; if2.start = 1;
        go_edge();
        if2.start = 0;
        for (int k = 1; k <= 50; k++) begin
            if (k > 1) go_edge();
            if (k == 18) begin
                chk1("t6 x15", int'(if2.x), 15);
                chk1("t6 data x15", int'(if2.data), 15);
            end
            if (k == 19) chk1("t6 data x16 wrap", int'(if2.data), 0);
            if (k == 47) chk1("t6 busy end", int'(if2.busy), 0);
        end

        @(negedge clk);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
